// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types for the IF/LS memory-port arbiter.
//   owner_e     : which requester owns the memory port (also used by fetch, LSU and trace logic)
//   arb_state_e : arbiter sequencing states
package mem_arbiter_pkg;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnLs = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } arb_state_e;

    // Round-robin preference: when both request, the side that did not win last goes first.
    function automatic owner_e rr_prefer(input owner_e last_owner);
        return (last_owner == OwnIf) ? OwnLs : OwnIf;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Purely combinational 2-way round-robin picker.
//   req_if_i     : fetch request
//   req_ls_i     : load/store request
//   last_owner_i : owner that won the previous arbitration
//   gnt_o        : one-hot grant, bit 0 = IF, bit 1 = LS (all zero when nobody requests)
//   winner_o     : index of the granted requester (don't-care when gnt_o is zero)
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       req_if_i,
    input  logic       req_ls_i,
    input  owner_e     last_owner_i,
    output logic [1:0] gnt_o,
    output owner_e     winner_o
);

    always_comb begin
        winner_o = OwnIf;
        if (req_if_i && req_ls_i) begin
            winner_o = rr_prefer(last_owner_i);
        end else if (req_ls_i) begin
            winner_o = OwnLs;
        end else begin
            winner_o = OwnIf;
        end
        gnt_o[0] = req_if_i && (winner_o == OwnIf);
        gnt_o[1] = req_ls_i && (winner_o == OwnLs);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between instruction fetch (IF) and the load/store unit (LS), with a
// single outstanding transaction and round-robin arbitration.
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   if_req_i/if_addr_i       : fetch request (held until if_gnt_o)
//   if_gnt_o                 : fetch accepted (combinational, IDLE only)
//   if_rvalid_o/if_rdata_o   : fetch response pulse and data
//   ls_req_i/we/be/addr/wdata: load/store request (held until ls_gnt_o)
//   ls_gnt_o                 : load/store accepted (combinational, IDLE only)
//   ls_rvalid_o/ls_rdata_o   : load data or store completion pulse (rdata 0 for stores)
//   mem_req_o..mem_wdata_o   : registered memory command
//   mem_gnt_i                : memory accepted the command
//   mem_rvalid_i/mem_rdata_i : memory response
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    // Owner of the current transaction; between transactions it is the last winner.
    owner_e              owner_q, owner_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [1:0]          pick_gnt;
    owner_e              pick_winner;
    logic                resp_valid;

    mem_arb_pick u_pick (
        .req_if_i     (if_req_i),
        .req_ls_i     (ls_req_i),
        .last_owner_i (owner_q),
        .gnt_o        (pick_gnt),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        resp_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by rstn_i so no grant leaks out while reset is held.
                if (rstn_i && (pick_gnt != 2'b00)) begin
                    if_gnt_o  = pick_gnt[0];
                    ls_gnt_o  = pick_gnt[1];
                    owner_d   = pick_winner;
                    mem_req_d = 1'b1;
                    state_d   = StReq;
                    if (pick_winner == OwnLs) begin
                        mem_we_d    = ls_we_i;
                        mem_be_d    = ls_be_i;
                        mem_addr_d  = ls_addr_i;
                        mem_wdata_d = ls_wdata_i;
                    end else begin
                        // Fetches are always full-word reads; wdata is zeroed as it has no source.
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            StReq: begin
                if (mem_gnt_i) begin
                    mem_req_d  = 1'b0;
                    // Response may arrive together with the grant.
                    resp_valid = mem_rvalid_i;
                    state_d    = mem_rvalid_i ? StIdle : StWait;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    resp_valid = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            owner_q     <= OwnIf;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        if_rvalid_o = resp_valid && (owner_q == OwnIf);
        ls_rvalid_o = resp_valid && (owner_q == OwnLs);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        // Stores complete with a pulse but carry no data.
        ls_rdata_o  = (ls_rvalid_o && !mem_we_q) ? mem_rdata_i : '0;
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a transaction-level reference (one outstanding command
// record plus the last winner) checked on every falling clock edge, plus directed scenarios
// with hand-computed literal expectations.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i = 1'b0;
    logic        ls_we_i = 1'b0;
    logic [3:0]  ls_be_i = '0;
    logic [31:0] ls_addr_i = '0;
    logic [31:0] ls_wdata_i = '0;
    logic        ls_gnt_o, ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_be_i      (ls_be_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_gnt_o     (ls_gnt_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .ls_rdata_o   (ls_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: is a transaction outstanding, has memory accepted it, what was latched,
    // and who won last (1 = LS).
    logic        m_busy, m_acc, m_last;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;

    logic        e_win_valid, e_win, e_resp;
    logic        e_if_gnt, e_ls_gnt, e_if_rvalid, e_ls_rvalid;
    logic [31:0] e_if_rdata, e_ls_rdata;

    always_comb begin
        e_win_valid = rstn_i && !m_busy && (if_req_i || ls_req_i);
        e_win       = (if_req_i && ls_req_i) ? !m_last : ls_req_i;
        e_if_gnt    = e_win_valid && !e_win;
        e_ls_gnt    = e_win_valid && e_win;
        e_resp      = rstn_i && m_busy && mem_rvalid_i && (m_acc || mem_gnt_i);
        e_if_rvalid = e_resp && !m_last;
        e_ls_rvalid = e_resp && m_last;
        e_if_rdata  = e_if_rvalid ? mem_rdata_i : 32'h0;
        e_ls_rdata  = (e_ls_rvalid && !m_we) ? mem_rdata_i : 32'h0;
    end

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_busy <= 1'b0; m_acc <= 1'b0; m_last <= 1'b0;
            m_we <= 1'b0; m_be <= '0; m_addr <= '0; m_wdata <= '0;
        end else if (e_win_valid) begin
            m_busy <= 1'b1;
            m_acc  <= 1'b0;
            m_last <= e_win;
            if (e_win) begin
                m_we <= ls_we_i; m_be <= ls_be_i; m_addr <= ls_addr_i; m_wdata <= ls_wdata_i;
            end else begin
                m_we <= 1'b0; m_be <= 4'hF; m_addr <= if_addr_i; m_wdata <= 32'h0;
            end
        end else if (m_busy) begin
            if (mem_gnt_i) m_acc <= 1'b1;
            if (e_resp) m_busy <= 1'b0;
        end
    end

    logic cmp_en = 1'b0;
    logic rec_en = 1'b0;
    logic order_q[$];

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("m_if_gnt", 32'(if_gnt_o), 32'(e_if_gnt));
            check("m_ls_gnt", 32'(ls_gnt_o), 32'(e_ls_gnt));
            check("m_if_rvalid", 32'(if_rvalid_o), 32'(e_if_rvalid));
            check("m_ls_rvalid", 32'(ls_rvalid_o), 32'(e_ls_rvalid));
            check("m_if_rdata", if_rdata_o, e_if_rdata);
            check("m_ls_rdata", ls_rdata_o, e_ls_rdata);
            check("m_mem_req", 32'(mem_req_o), 32'(m_busy && !m_acc));
            check("m_mem_we", 32'(mem_we_o), 32'(m_we));
            check("m_mem_be", 32'(mem_be_o), 32'(m_be));
            check("m_mem_addr", mem_addr_o, m_addr);
            check("m_mem_wdata", mem_wdata_o, m_wdata);
        end
        if (rec_en) begin
            if (if_gnt_o) order_q.push_back(1'b0);
            if (ls_gnt_o) order_q.push_back(1'b1);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_if_gnt"}, 32'(if_gnt_o), 32'h0);
        check({tag, "_ls_gnt"}, 32'(ls_gnt_o), 32'h0);
        check({tag, "_if_rvalid"}, 32'(if_rvalid_o), 32'h0);
        check({tag, "_ls_rvalid"}, 32'(ls_rvalid_o), 32'h0);
        check({tag, "_if_rdata"}, if_rdata_o, 32'h0);
        check({tag, "_ls_rdata"}, ls_rdata_o, 32'h0);
        check({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
        check({tag, "_mem_be"}, 32'(mem_be_o), 32'h0);
        check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_order[3];
        exp_order = '{1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (2) cyc();
        cmp_en = 1'b1;
        check_zero("rst");
        rstn_i = 1'b1;
        cyc();

        // IF-only fetch, memory grants immediately, data one cycle later
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        #1;
        check("t1_if_gnt", 32'(if_gnt_o), 32'h1);
        check("t1_ls_gnt", 32'(ls_gnt_o), 32'h0);
        cyc();
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        check("t1_mem_req", 32'(mem_req_o), 32'h1);
        check("t1_mem_addr", mem_addr_o, 32'h0000_0100);
        check("t1_mem_we", 32'(mem_we_o), 32'h0);
        check("t1_mem_be", 32'(mem_be_o), 32'hF);
        cyc();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
        #1;
        check("t1_if_rvalid", 32'(if_rvalid_o), 32'h1);
        check("t1_if_rdata", if_rdata_o, 32'h0000_0013);
        check("t1_ls_rvalid", 32'(ls_rvalid_o), 32'h0);
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #1;
        check("t1_if_rvalid_end", 32'(if_rvalid_o), 32'h0);

        // Simultaneous requests from reset, three transactions
        rstn_i = 1'b0;
        cyc();
        rstn_i = 1'b1;
        cyc();
        if_req_i = 1'b1; if_addr_i = 32'h200;
        ls_req_i = 1'b1; ls_addr_i = 32'h300; ls_we_i = 1'b0; ls_be_i = 4'hF;
        rec_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_gnt_i = 1'b1;
            cyc();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'(i + 1);
            if (i == 2) begin
                if_req_i = 1'b0; ls_req_i = 1'b0;
            end
            cyc();
            mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        end
        #1;
        rec_en = 1'b0;
        check("t2_gnt_count", 32'(order_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < order_q.size()) check("t2_gnt_order", 32'(order_q[i]), 32'(exp_order[i]));
        end

        // LS store with memory grant delayed 3 cycles
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0011;
        ls_addr_i = 32'h2000; ls_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("t3_ls_gnt", 32'(ls_gnt_o), 32'h1);
        cyc();
        ls_req_i = 1'b0; ls_addr_i = 32'h9999; ls_wdata_i = 32'h0; ls_be_i = 4'hC;
        for (int k = 0; k < 4; k++) begin
            mem_gnt_i = (k == 3);
            #1;
            check("t3_mem_req", 32'(mem_req_o), 32'h1);
            check("t3_mem_addr", mem_addr_o, 32'h2000);
            check("t3_mem_we", 32'(mem_we_o), 32'h1);
            check("t3_mem_be", 32'(mem_be_o), 32'h3);
            check("t3_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            cyc();
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #1;
        check("t3_mem_req_low", 32'(mem_req_o), 32'h0);
        check("t3_ls_rvalid", 32'(ls_rvalid_o), 32'h1);
        check("t3_ls_rdata", ls_rdata_o, 32'h0);
        check("t3_if_rvalid", 32'(if_rvalid_o), 32'h0);
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Same-cycle grant and response on an LS load
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h3000;
        #1;
        check("t4_ls_gnt", 32'(ls_gnt_o), 32'h1);
        cyc();
        ls_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        #1;
        check("t4_ls_rvalid", 32'(ls_rvalid_o), 32'h1);
        check("t4_ls_rdata", ls_rdata_o, 32'hCAFE_F00D);
        cyc();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        if_req_i = 1'b1; if_addr_i = 32'h400;
        #1;
        check("t4_idle_if_gnt", 32'(if_gnt_o), 32'h1);
        cyc();
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0042;
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Stray response in IDLE
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t5_if_rvalid", 32'(if_rvalid_o), 32'h0);
            check("t5_ls_rvalid", 32'(ls_rvalid_o), 32'h0);
            check("t5_mem_req", 32'(mem_req_o), 32'h0);
            cyc();
        end
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        ls_req_i = 1'b1; ls_addr_i = 32'h5000; ls_we_i = 1'b0;
        #1;
        check("t5_still_idle_gnt", 32'(ls_gnt_o), 32'h1);

        // Reset while in WAIT; LS won last, so reset must restore IF as last owner
        cyc();
        ls_req_i = 1'b0; mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0;
        #1;
        rstn_i = 1'b0; if_req_i = 1'b1; ls_req_i = 1'b1;
        #1;
        check_zero("t6a");
        cyc();
        check_zero("t6b");
        if_req_i = 1'b0; ls_req_i = 1'b0;
        cyc();
        rstn_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
        #1;
        check("t6_if_rvalid", 32'(if_rvalid_o), 32'h0);
        check("t6_ls_rvalid", 32'(ls_rvalid_o), 32'h0);
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        if_req_i = 1'b1; if_addr_i = 32'h600;
        ls_req_i = 1'b1; ls_addr_i = 32'h700;
        #1;
        check("t6_ls_gnt", 32'(ls_gnt_o), 32'h1);
        check("t6_if_gnt", 32'(if_gnt_o), 32'h0);
        cyc();
        if_req_i = 1'b0; ls_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        check("t6_mem_addr", mem_addr_o, 32'h700);
        cyc();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0088;
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        cyc();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
